dir_listing_buf: RTL and testbench
==================================

// Module: dir_listing_buf
// PURPOSE
//  Directory-listing store between the SD FAT directory scanner (writer) and the ASCII OSD (reader).
//  The scanner streams entry names byte-by-byte and the block stores them as fixed 16-column rows.
//  The OSD fetches characters by row/column and signals a file choice by index.
//  The block answers a choice with the start cluster of the chosen entry for the SD image loader.
// PARAMETERS
//  MAX_ENTRIES  32  rows stored; entries beyond this are dropped (dir_len saturates)
//  CLUSTER_W    32  width of stored start cluster per entry
// PORTS
//  clk            in   1          system clock
//  resetn         in   1          synchronous reset, active low
//  scan_start     in   1          pulse: new listing begins; clears dir_len, aborts partial entry
//  ent_valid      in   1          scanner name byte valid
//  ent_ready      out  1          block accepts byte (valid&&ready = transfer)
//  ent_chr        in   8          name byte
//  ent_last       in   1          marks final byte of current name
//  ent_is_dir     in   1          entry is a directory, sampled with first byte
//  ent_cluster    in   CLUSTER_W  start cluster, sampled on last-byte transfer
//  dir_row        in   8          OSD row request
//  dir_col        in   4          OSD column request
//  dir_chr        out  8          character at (dir_row,dir_col), 1-cycle latency
//  dir_len        out  6          committed entry count, 0..MAX_ENTRIES
//  file_selected  in   1          OSD pulse: entry file_index chosen
//  file_index     in   8          chosen row
//  sel_valid      out  1          1-cycle pulse: sel_cluster/sel_index valid
//  sel_index      out  8          accepted index
//  sel_cluster    out  CLUSTER_W  start cluster of accepted entry
// BEHAVIOUR
//  Reset: ent_ready=0, dir_chr=8'h20, dir_len=0, sel_valid=0, sel_index=0, sel_cluster=0; FSM=IDLE.
//  Storage: char RAM MAX_ENTRIES x 16 x 8 (write port: FSM, read port: OSD); cluster RAM MAX_ENTRIES x CLUSTER_W.
//  Row layout: col0=' ', cols1..15 = name, truncated to 15 chars, padded with ' ' (8'h20).
//  Write FSM (wr_row = dir_len, wr_col counter 4b):
//   IDLE: ent_ready=1. First transfer writes col1, goes to NAME (SKIP if dir_len==MAX_ENTRIES).
//   NAME: ent_ready=1. Each transfer writes wr_col, wr_col++.
//    ent_last at wr_col<15 -> PAD. ent_last at wr_col==15 -> COMMIT.
//    !ent_last at wr_col==15 -> write, then SKIP.
//   SKIP: ent_ready=1, bytes discarded. ent_last -> COMMIT (or IDLE if buffer was full).
//   PAD: ent_ready=0. Writes ' ' to each column up to 15, one per cycle, then COMMIT.
//   COMMIT: ent_ready=0, one cycle. Writes cluster RAM[wr_row], col0=' ', dir_len++, -> IDLE.
//   Single-byte name (ent_last on first byte) goes straight to PAD.
//  scan_start (any state): FSM->IDLE, dir_len<=0, partial entry discarded, ent_ready=0 that cycle.
//   Has priority over a coincident byte transfer and over file_selected.
//  Read: dir_chr registered one cycle after dir_row/dir_col.
//   dir_row>=dir_len or dir_row>=MAX_ENTRIES -> 8'h20. Rows still being written read as ' '.
//  Selection: file_selected && file_index<dir_len -> next cycle sel_valid=1,
//   sel_index=file_index, sel_cluster=cluster RAM[file_index].
//   file_index>=dir_len (incl. dir_len==0) is ignored: no pulse, outputs held.
//   Back-to-back selections each produce a pulse. Accepted mid-scan against the current dir_len.
//  dir_len width: 6 bits, compare against 8-bit indices is zero-extended; saturates at MAX_ENTRIES.
// CONFIGURATION
//  DIR_MARK_EN defined: when ent_is_dir=1, col1 is forced to '/' in IDLE (same cycle as the first byte).
//   The name starts at col2, truncated to 14 chars; remaining PAD/SKIP rules unchanged.
//  DIR_MARK_EN undefined: ent_is_dir ignored; directories are stored exactly like files.
// TESTING
//  1. Reset, scan_start, stream "GAME.ST"+last, cluster 0x123 -> dir_len=1.
//     Row0 col1..7="GAME.ST", cols8..15=' ', col0=' '.
//  2. 20-char name -> cols1..15 = first 15 chars; ent_ready held high through SKIP; dir_len+1.
//  3. 33 single-char entries -> dir_len=32; 33rd accepted/dropped; read row 32 -> 8'h20.
//  4. Entries clusters 0x10,0x20,0x30; file_selected idx1 -> sel_valid 1 cycle later, cluster 0x20.
//     idx3 -> no pulse.
//  5. scan_start mid-name after 2 entries -> dir_len=0, row0 reads ' ', next name lands in row0.
//  6. DIR_MARK_EN, dir "TOS" -> row0 col1='/', col2..4="TOS"; without macro col1..3="TOS".

Source files
------------

// File: rtl/dir_listing_buf.sv
// rtl/dir_listing_buf.sv - directory listing row store between FAT scanner and OSD (option: DIR_MARK_EN)
module dir_listing_buf #(
    parameter int MAX_ENTRIES = 32,
    parameter int CLUSTER_W   = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 scan_start,
    input  logic                 ent_valid,
    output logic                 ent_ready,
    input  logic [7:0]           ent_chr,
    input  logic                 ent_last,
    input  logic                 ent_is_dir,
    input  logic [CLUSTER_W-1:0] ent_cluster,
    input  logic [7:0]           dir_row,
    input  logic [3:0]           dir_col,
    output logic [7:0]           dir_chr,
    output logic [5:0]           dir_len,
    input  logic                 file_selected,
    input  logic [7:0]           file_index,
    output logic                 sel_valid,
    output logic [7:0]           sel_index,
    output logic [CLUSTER_W-1:0] sel_cluster
);
    localparam int RW = $clog2(MAX_ENTRIES);
    localparam logic [5:0] MAX_LEN = 6'(MAX_ENTRIES);
    localparam logic [7:0] SP = 8'h20;

    typedef enum logic [2:0] {S_IDLE, S_NAME, S_SKIP, S_PAD, S_COMMIT} state_t;

    state_t               state;
    logic                 rdy_q;
    logic                 drop;
    logic [3:0]           wr_col;
    logic [CLUSTER_W-1:0] clu_hold;
    logic [7:0]           chr_mem [MAX_ENTRIES*16];
    logic [CLUSTER_W-1:0] clu_mem [MAX_ENTRIES];

    logic          xfer;
    logic          full;
    logic          take_name;
    logic [3:0]    first_col;
    logic [3:0]    cur_col;
    logic [RW-1:0] wr_row;

    assign ent_ready = rdy_q && !scan_start;
    assign xfer      = ent_valid && ent_ready;
    assign full      = (dir_len == MAX_LEN);
    assign wr_row    = dir_len[RW-1:0];
    assign take_name = xfer && ((state == S_NAME) || ((state == S_IDLE) && !full));
    assign cur_col   = (state == S_IDLE) ? first_col : wr_col;

`ifdef DIR_MARK_EN
    assign first_col = ent_is_dir ? 4'd2 : 4'd1;
`else
    assign first_col = 4'd1;
    logic unused_is_dir;
    assign unused_is_dir = ent_is_dir;
`endif

    // Write side: a name byte lands at cur_col; what follows depends on ent_last and the column reached.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            rdy_q    <= 1'b0;
            drop     <= 1'b0;
            wr_col   <= 4'd0;
            dir_len  <= 6'd0;
            clu_hold <= '0;
        end else if (scan_start) begin
            state   <= S_IDLE;
            rdy_q   <= 1'b1;
            drop    <= 1'b0;
            wr_col  <= 4'd0;
            dir_len <= 6'd0;
        end else if (take_name) begin
`ifdef DIR_MARK_EN
            if ((state == S_IDLE) && ent_is_dir)
                chr_mem[{wr_row, 4'd1}] <= 8'h2F;
`endif
            chr_mem[{wr_row, cur_col}] <= ent_chr;
            wr_col <= cur_col + 4'd1;
            if (ent_last) begin
                clu_hold <= ent_cluster;
                rdy_q    <= 1'b0;
                state    <= (cur_col == 4'd15) ? S_COMMIT : S_PAD;
            end else begin
                state    <= (cur_col == 4'd15) ? S_SKIP : S_NAME;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    rdy_q <= 1'b1;
                    // Buffer full: swallow the whole name without touching storage.
                    if (xfer && !ent_last) begin
                        drop  <= 1'b1;
                        state <= S_SKIP;
                    end
                end
                S_SKIP: begin
                    if (xfer && ent_last) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            clu_hold <= ent_cluster;
                            rdy_q    <= 1'b0;
                            state    <= S_COMMIT;
                        end
                    end
                end
                S_PAD: begin
                    chr_mem[{wr_row, wr_col}] <= SP;
                    if (wr_col == 4'd15)
                        state <= S_COMMIT;
                    else
                        wr_col <= wr_col + 4'd1;
                end
                S_COMMIT: begin
                    chr_mem[{wr_row, 4'd0}] <= SP;
                    clu_mem[wr_row]         <= clu_hold;
                    dir_len                 <= dir_len + 6'd1;
                    rdy_q                   <= 1'b1;
                    state                   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Only committed rows are visible, so rows under construction read as blanks.
    always_ff @(posedge clk) begin
        if (!resetn)
            dir_chr <= SP;
        else if (dir_row < {2'b00, dir_len})
            dir_chr <= chr_mem[{dir_row[RW-1:0], dir_col}];
        else
            dir_chr <= SP;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sel_valid   <= 1'b0;
            sel_index   <= 8'd0;
            sel_cluster <= '0;
        end else begin
            sel_valid <= 1'b0;
            if (file_selected && !scan_start && (file_index < {2'b00, dir_len})) begin
                sel_valid   <= 1'b1;
                sel_index   <= file_index;
                sel_cluster <= clu_mem[file_index[RW-1:0]];
            end
        end
    end
endmodule

// File: tb/tb_dir_listing_buf.sv
// tb/tb_dir_listing_buf.sv - directed self-checking bench for dir_listing_buf
module tb_dir_listing_buf;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        scan_start = 1'b0;
    logic        ent_valid = 1'b0;
    logic        ent_ready;
    logic [7:0]  ent_chr = 8'h00;
    logic        ent_last = 1'b0;
    logic        ent_is_dir = 1'b0;
    logic [31:0] ent_cluster = 32'h0;
    logic [7:0]  dir_row = 8'h00;
    logic [3:0]  dir_col = 4'h0;
    logic [7:0]  dir_chr;
    logic [5:0]  dir_len;
    logic        file_selected = 1'b0;
    logic [7:0]  file_index = 8'h00;
    logic        sel_valid;
    logic [7:0]  sel_index;
    logic [31:0] sel_cluster;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dir_listing_buf dut (
        .clk(clk), .resetn(resetn), .scan_start(scan_start),
        .ent_valid(ent_valid), .ent_ready(ent_ready), .ent_chr(ent_chr),
        .ent_last(ent_last), .ent_is_dir(ent_is_dir), .ent_cluster(ent_cluster),
        .dir_row(dir_row), .dir_col(dir_col), .dir_chr(dir_chr), .dir_len(dir_len),
        .file_selected(file_selected), .file_index(file_index),
        .sel_valid(sel_valid), .sel_index(sel_index), .sel_cluster(sel_cluster)
    );

    function automatic logic [7:0] exp_chr(string s, int col, bit is_dir);
        int first = 1;
        if (col == 0) return 8'h20;
`ifdef DIR_MARK_EN
        if (is_dir) begin
            if (col == 1) return 8'h2F;
            first = 2;
        end
`endif
        if ((col - first) < s.len()) return s[col - first];
        return 8'h20;
    endfunction

    task automatic send_byte(input logic [7:0] c, input logic last, input logic [31:0] clu,
                             input logic is_dir, output int waited);
        ent_chr = c; ent_last = last; ent_cluster = clu; ent_is_dir = is_dir; ent_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (ent_ready) break;
            waited++;
            if (waited > 100) begin
                checks++; errors++;
                $display("FAIL send_byte timeout: ent_ready stayed %b, required 1", ent_ready);
                break;
            end
        end
        @(posedge clk); #1;
        ent_valid = 1'b0; ent_last = 1'b0;
    endtask

    task automatic send_name(input string s, input logic [31:0] clu, input logic is_dir);
        int w;
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], i == s.len() - 1, clu, is_dir, w);
    endtask

    task automatic wait_ready();
        int n = 0;
        forever begin
            @(negedge clk);
            if (ent_ready) break;
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL wait_ready timeout: ent_ready %b, required 1", ent_ready);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic read_chr(input logic [7:0] row, input logic [3:0] col, output logic [7:0] v);
        dir_row = row; dir_col = col;
        @(posedge clk); #1;
        v = dir_chr;
    endtask

    task automatic pulse_scan();
        scan_start = 1'b1;
        #1;
        checks++;
        if (ent_ready !== 1'b0) begin
            errors++;
            $display("FAIL scan_ready: ent_ready %b, required 0", ent_ready);
        end
        @(posedge clk); #1;
        scan_start = 1'b0;
    endtask

    task automatic check_row(input logic [7:0] row, input string s, input bit is_dir, input string tag);
        logic [7:0] v;
        for (int c = 0; c < 16; c++) begin
            read_chr(row, 4'(c), v);
            checks++;
            if (v !== exp_chr(s, c, is_dir)) begin
                errors++;
                $display("FAIL %s row %0d col %0d: got %h, required %h", tag, row, c, v, exp_chr(s, c, is_dir));
            end
        end
    endtask

    task automatic check_len(input logic [5:0] exp, input string tag);
        checks++;
        if (dir_len !== exp) begin
            errors++;
            $display("FAIL %s dir_len: got %0d, required %0d", tag, dir_len, exp);
        end
    endtask

    task automatic select(input logic [7:0] idx);
        file_selected = 1'b1; file_index = idx;
        @(posedge clk); #1;
        file_selected = 1'b0;
    endtask

    task automatic check_sel(input logic v, input logic [7:0] idx, input logic [31:0] clu, input string tag);
        checks++;
        if (sel_valid !== v || (v && (sel_index !== idx || sel_cluster !== clu))) begin
            errors++;
            $display("FAIL %s: sel_valid %b idx %0d cluster %h, required %b idx %0d cluster %h",
                     tag, sel_valid, sel_index, sel_cluster, v, idx, clu);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ent_ready !== 1'b0 || dir_chr !== 8'h20 || dir_len !== 6'd0 || sel_valid !== 1'b0 ||
            sel_index !== 8'd0 || sel_cluster !== 32'd0) begin
            errors++;
            $display("FAIL reset: ready %b chr %h len %0d sv %b si %0d sc %h, required 0 20 0 0 0 0",
                     ent_ready, dir_chr, dir_len, sel_valid, sel_index, sel_cluster);
        end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        pulse_scan();
        send_name("GAME.ST", 32'h123, 1'b0);
        wait_ready();
        check_len(6'd1, "basic");
        check_row(8'd0, "GAME.ST", 1'b0, "basic");
    endtask

    task automatic test_long();
        string s = "ABCDEFGHIJKLMNOPQRST";
        int w;
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], i == s.len() - 1, 32'h456, 1'b0, w);
            if (i >= 15) begin
                checks++;
                if (w != 0) begin
                    errors++;
                    $display("FAIL long_skip byte %0d: waited %0d cycles, required 0", i, w);
                end
            end
        end
        wait_ready();
        check_len(6'd2, "long");
        check_row(8'd1, "ABCDEFGHIJKLMNO", 1'b0, "long");
    endtask

    task automatic test_select();
        pulse_scan();
        send_name("A", 32'h10, 1'b0);
        send_name("B", 32'h20, 1'b0);
        send_name("C", 32'h30, 1'b0);
        wait_ready();
        check_len(6'd3, "select");
        select(8'd1);
        check_sel(1'b1, 8'd1, 32'h20, "sel_idx1");
        @(posedge clk); #1;
        check_sel(1'b0, 8'd0, 32'h0, "sel_pulse_end");
        select(8'd3);
        check_sel(1'b0, 8'd0, 32'h0, "sel_idx3_ignored");
        checks++;
        if (sel_index !== 8'd1 || sel_cluster !== 32'h20) begin
            errors++;
            $display("FAIL sel_hold: idx %0d cluster %h, required 1 00000020", sel_index, sel_cluster);
        end
        file_selected = 1'b1; file_index = 8'd0;
        @(posedge clk); #1;
        check_sel(1'b1, 8'd0, 32'h10, "sel_b2b_first");
        file_index = 8'd2;
        @(posedge clk); #1;
        file_selected = 1'b0;
        check_sel(1'b1, 8'd2, 32'h30, "sel_b2b_second");
    endtask

    task automatic test_full();
        logic [7:0] v;
        string s;
        int w;
        pulse_scan();
        for (int i = 0; i < 33; i++) begin
            s = " ";
            s[0] = 8'(8'h41 + (i % 26));
            send_name(s, 32'(i), 1'b0);
        end
        wait_ready();
        check_len(6'd32, "full");
        read_chr(8'd31, 4'd1, v);
        checks++;
        if (v !== 8'h46) begin
            errors++;
            $display("FAIL full_row31: got %h, required 46", v);
        end
        read_chr(8'd32, 4'd1, v);
        checks++;
        if (v !== 8'h20) begin
            errors++;
            $display("FAIL full_row32: got %h, required 20", v);
        end
        send_name("XYZ", 32'h99, 1'b0);
        wait_ready();
        check_len(6'd32, "full_multi_drop");
        select(8'd31);
        check_sel(1'b1, 8'd31, 32'd31, "full_sel31");
        select(8'd32);
        check_sel(1'b0, 8'd0, 32'h0, "full_sel32");
        send_byte(8'h51, 1'b1, 32'h0, 1'b0, w);
        checks++;
        if (w > 20) begin
            errors++;
            $display("FAIL full_accept: waited %0d cycles, required <=20", w);
        end
    endtask

    task automatic test_abort();
        int w;
        pulse_scan();
        send_name("ONE", 32'h1, 1'b0);
        send_name("TWO", 32'h2, 1'b0);
        wait_ready();
        check_len(6'd2, "abort_pre");
        send_byte(8'h58, 1'b0, 32'h0, 1'b0, w);
        send_byte(8'h59, 1'b0, 32'h0, 1'b0, w);
        pulse_scan();
        check_len(6'd0, "abort");
        check_row(8'd0, "", 1'b0, "abort_blank");
        send_name("Q", 32'h77, 1'b0);
        wait_ready();
        check_len(6'd1, "abort_next");
        check_row(8'd0, "Q", 1'b0, "abort_next");
        select(8'd0);
        check_sel(1'b1, 8'd0, 32'h77, "abort_sel");
    endtask

    task automatic test_dir_mark();
        pulse_scan();
        send_name("TOS", 32'h5, 1'b1);
        wait_ready();
        check_len(6'd1, "dir");
        check_row(8'd0, "TOS", 1'b1, "dir");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_long();
        test_select();
        test_full();
        test_abort();
        test_dir_mark();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
